// File: rtl/md_pkg.sv
// Shared opcode constants, FSM state type and opcode classifiers for the MD unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_DIV   = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MFHI  = 4'd6;
  localparam logic [3:0] MD_MFLO  = 4'd7;
  localparam logic [3:0] MD_NONE  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY
  } md_state_e;

  // MULT/DIV/MULTU/DIVU: ops that launch into the datapath
  function automatic logic is_md_arith(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  // Any MD-class op (0..7); everything else behaves as NONE
  function automatic logic is_md_any(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  // Divide ops use the divider latency
  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter tracking remaining MD latency; last flags the result cycle.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Load on accept, otherwise count down while an op is in flight (saturates at 0)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the multiply/divide unit: launches ops, counts
// their latency, stalls the pipeline while HI/LO are in use.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [3:0] ex_op,
  input  logic       ex_flush,
  output logic       stall,
  output logic       md_start,
  output logic [3:0] md_op,
  output logic       busy,
  output logic       hilo_we,
  output logic       hi_we,
  output logic       lo_we
);

  md_state_e        state, state_nxt;
  logic             accept;
  logic             cnt_last;
  logic [CNT_W-1:0] lat_sel;
  logic             idle;

  assign idle    = (state == ST_IDLE);
  assign accept  = idle && ex_valid && !ex_flush && is_md_arith(ex_op);
  assign lat_sel = is_md_div(ex_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (lat_sel),
    .dec      (!idle),
    .last     (cnt_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs (depend only on registered state/count)
  always_comb begin
    state_nxt = state;
    md_start  = 1'b0;
    busy      = 1'b0;
    hilo_we   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        md_start = 1'b1;
        busy     = 1'b1;
        if (cnt_last) begin
          hilo_we   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt_last) begin
          hilo_we   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Opcode in flight: captured on accept, returns to NONE after the result write
  always_ff @(posedge clk) begin
    if (reset) begin
      md_op <= MD_NONE;
    end else if (accept) begin
      md_op <= ex_op;
    end else if (hilo_we) begin
      md_op <= MD_NONE;
    end
  end

  // Stall holds even under flush; the flush takes effect once the pipe advances
  assign stall = ex_valid && is_md_any(ex_op) && !idle;
  assign hi_we = idle && ex_valid && !ex_flush && (ex_op == MD_MTHI);
  assign lo_we = idle && ex_valid && !ex_flush && (ex_op == MD_MTLO);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: default latencies and a short-latency instance.
module tb_md_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       ex_valid;
  logic [3:0] ex_op;
  logic       ex_flush;

  logic       stall0, md_start0, busy0, hilo_we0, hi_we0, lo_we0;
  logic [3:0] md_op0;
  logic       stall1, md_start1, busy1, hilo_we1, hi_we1, lo_we1;
  logic [3:0] md_op1;

  logic [9:0] got [2];

  int vectors;
  int miscompares;

  // Reference model: cycles of occupancy remaining (0 = free)
  int         rem   [2];
  bit         first [2];
  logic [3:0] mop   [2];

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_flush(ex_flush),
    .stall(stall0), .md_start(md_start0), .md_op(md_op0), .busy(busy0),
    .hilo_we(hilo_we0), .hi_we(hi_we0), .lo_we(lo_we0)
  );

  md_issue_ctrl #(.MULT_LAT(1), .DIV_LAT(2), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_flush(ex_flush),
    .stall(stall1), .md_start(md_start1), .md_op(md_op1), .busy(busy1),
    .hilo_we(hilo_we1), .hi_we(hi_we1), .lo_we(lo_we1)
  );

  assign got[0] = {stall0, md_start0, md_op0, busy0, hilo_we0, hi_we0, lo_we0};
  assign got[1] = {stall1, md_start1, md_op1, busy1, hilo_we1, hi_we1, lo_we1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int i, input logic [3:0] op);
    bit dv;
    dv = (op == 4'd1) || (op == 4'd3);
    if (i == 0) return dv ? 10 : 5;
    return dv ? 2 : 1;
  endfunction

  // Expected {stall, md_start, md_op, busy, hilo_we, hi_we, lo_we} for instance i
  function automatic logic [9:0] expv(input int i);
    logic s, ms, b, hw, hiw, low;
    logic [3:0] o;
    s   = ex_valid && (ex_op <= 4'd7) && (rem[i] > 0);
    ms  = (rem[i] > 0) && first[i];
    o   = (rem[i] > 0) ? mop[i] : 4'd15;
    b   = (rem[i] > 0);
    hw  = (rem[i] == 1);
    hiw = (rem[i] == 0) && ex_valid && !ex_flush && (ex_op == 4'd4);
    low = (rem[i] == 0) && ex_valid && !ex_flush && (ex_op == 4'd5);
    return {s, ms, o, b, hw, hiw, low};
  endfunction

  // Advance one clock: update the model at the edge, return at the next negedge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rem[i] = 0; first[i] = 0; mop[i] = 4'd15;
      end else if (rem[i] > 0) begin
        rem[i]--; first[i] = 0;
      end else if (ex_valid && !ex_flush && (ex_op <= 4'd3)) begin
        rem[i] = lat(i, ex_op); first[i] = 1; mop[i] = ex_op;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    ex_valid = 1'b0; ex_op = 4'd15; ex_flush = 1'b0;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ex_op = 4'd15; ex_flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (got[i] !== 10'b0_0_1111_0_0_0_0) begin
        $display("FAIL reset dut%0d got=%b exp=%b", i, got[i], 10'b0_0_1111_0_0_0_0);
        miscompares++;
      end
    end
    tick();
  endtask

  task automatic test_mult_latency();
    int ms_at, hw_at;
    ms_at = -1; hw_at = -1;
    for (int c = 0; c < 8; c++) begin
      ex_valid = (c == 0); ex_op = (c == 0) ? 4'd0 : 4'd15; ex_flush = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL mult_latency dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (md_start0 && ms_at < 0) ms_at = c;
      if (hilo_we0 && hw_at < 0) hw_at = c;
      if (c == 6) begin
        vectors++;
        if (busy0 !== 1'b0 || md_op0 !== 4'd15) begin
          $display("FAIL mult_idle busy=%b md_op=%0d exp busy=0 md_op=15", busy0, md_op0);
          miscompares++;
        end
      end
      tick();
    end
    vectors++;
    if (ms_at != 1 || hw_at != 5) begin
      $display("FAIL mult_timing md_start_at=%0d hilo_we_at=%0d exp 1 and 5", ms_at, hw_at);
      miscompares++;
    end
  endtask

  task automatic test_divu_mflo();
    int nostall_at, hw_at, stalls;
    nostall_at = -1; hw_at = -1; stalls = 0;
    for (int c = 0; c < 16 && nostall_at < 0; c++) begin
      ex_valid = 1'b1; ex_op = (c == 0) ? 4'd3 : 4'd7; ex_flush = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL divu_mflo dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (c >= 1 && stall0) stalls++;
      if (c >= 1 && !stall0) nostall_at = c;
      if (hilo_we0 && hw_at < 0) hw_at = c;
      tick();
    end
    vectors++;
    if (nostall_at != 11 || hw_at != 10 || stalls != 10) begin
      $display("FAIL divu_stall release_at=%0d hilo_we_at=%0d stalls=%0d exp 11 10 10",
               nostall_at, hw_at, stalls);
      miscompares++;
    end
    drain();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      ex_valid = (c < 2); ex_flush = (c < 2);
      ex_op = (c == 0) ? 4'd1 : ((c == 1) ? 4'd4 : 4'd15);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL flush dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (c >= 1) begin
        vectors++;
        if (md_start0 !== 1'b0 || busy0 !== 1'b0 || hi_we0 !== 1'b0) begin
          $display("FAIL flush_kill c=%0d md_start=%b busy=%b hi_we=%b exp 0 0 0",
                   c, md_start0, busy0, hi_we0);
          miscompares++;
        end
      end
      tick();
    end
  endtask

  task automatic test_mtlo_mthi();
    for (int c = 0; c < 9; c++) begin
      ex_valid = 1'b1; ex_flush = 1'b0;
      ex_op = (c == 0) ? 4'd5 : ((c == 1) ? 4'd0 : 4'd4);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL mtlo_mthi dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (c == 0) begin
        vectors++;
        if (lo_we0 !== 1'b1 || stall0 !== 1'b0) begin
          $display("FAIL mtlo_idle lo_we=%b stall=%b exp 1 0", lo_we0, stall0);
          miscompares++;
        end
      end
      if (c == 2) begin
        vectors++;
        if (stall0 !== 1'b1 || hi_we0 !== 1'b0) begin
          $display("FAIL mthi_busy stall=%b hi_we=%b exp 1 0", stall0, hi_we0);
          miscompares++;
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int hw_seen;
    hw_seen = 0;
    for (int c = 0; c < 18; c++) begin
      ex_valid = (c == 0); ex_op = (c == 0) ? 4'd1 : 4'd15; ex_flush = 1'b0;
      reset = (c == 4);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL reset_midop dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (hilo_we0) hw_seen++;
      if (c == 5) begin
        vectors++;
        if (busy0 !== 1'b0 || md_op0 !== 4'd15) begin
          $display("FAIL reset_midop_state busy=%b md_op=%0d exp 0 15", busy0, md_op0);
          miscompares++;
        end
      end
      tick();
    end
    reset = 1'b0;
    vectors++;
    if (hw_seen != 0) begin
      $display("FAIL reset_midop_hilo hilo_we_pulses=%0d exp 0", hw_seen);
      miscompares++;
    end
  endtask

  task automatic test_param_edge();
    for (int c = 0; c < 8; c++) begin
      ex_valid = (c == 0); ex_op = (c == 0) ? 4'd2 : 4'd15; ex_flush = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL param_edge dut%0d c=%0d got=%b exp=%b", i, c, got[i], expv(i));
          miscompares++;
        end
      end
      if (c == 1) begin
        vectors++;
        if (md_start1 !== 1'b1 || hilo_we1 !== 1'b1 || md_op1 !== 4'd2) begin
          $display("FAIL lat1_pulse md_start=%b hilo_we=%b md_op=%0d exp 1 1 2",
                   md_start1, hilo_we1, md_op1);
          miscompares++;
        end
      end
      if (c == 2) begin
        vectors++;
        if (busy1 !== 1'b0 || md_op1 !== 4'd15) begin
          $display("FAIL lat1_idle busy=%b md_op=%0d exp 0 15", busy1, md_op1);
          miscompares++;
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset    = ($urandom_range(0, 59) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_flush = ($urandom_range(0, 5) == 0);
      ex_op    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                             : 4'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got[i] !== expv(i)) begin
          $display("FAIL random dut%0d c=%0d op=%0d v=%b f=%b r=%b got=%b exp=%b",
                   i, c, ex_op, ex_valid, ex_flush, reset, got[i], expv(i));
          miscompares++;
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; first[i] = 0; mop[i] = 4'd15;
    end
    reset = 1'b1; ex_valid = 1'b0; ex_op = 4'd15; ex_flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_mult_latency();
    test_divu_mflo();
    test_flush();
    test_mtlo_mthi();
    test_reset_midop();
    test_param_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
